// File: rtl/lvds_capture_pkg.sv
// Shared definitions for the LVDS ping-pong capture block: register map,
// CTRL/STATUS bit positions, FSM encodings and a saturating counter helper.
package lvds_capture_pkg;

    // Register offsets (only address bits [12:0] are decoded)
    localparam logic [12:0] A_CTRL     = 13'h000;
    localparam logic [12:0] A_STATUS   = 13'h004;
    localparam logic [12:0] A_WPTR     = 13'h008;
    localparam logic [12:0] A_IRQ_MASK = 13'h00C;

    // CTRL bits
    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_REL0    = 1;
    localparam int CTRL_REL1    = 2;
    localparam int CTRL_CLR_OVF = 3;

    // STATUS bits
    localparam int ST_RDY0   = 0;
    localparam int ST_RDY1   = 1;
    localparam int ST_ACTIVE = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_STALL  = 4;

    // Capture FSM
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    // AXI read FSM
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_RAM  = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lvds_cap_ram.sv
// Simple dual-port sample RAM holding both ping-pong buffers.
// Address MSB selects the buffer; read data is registered (one cycle latency).
module lvds_cap_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Packer write port and registered AXI read port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lvds_capture_pingpong.sv
// LVDS sample capture into two ping-pong buffers, AXI4-Lite status/readback.
// Optional feature macro: CAP_IRQ_EN (adds IRQ port and IRQ_MASK register).
module lvds_capture_pingpong
    import lvds_capture_pkg::*;
#(
    parameter int C_NUM_LANES        = 4,
    parameter int C_BUF_DEPTH        = 128,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [C_NUM_LANES-1:0]          LVDS_DATA,
    input  logic                            LVDS_VALID,
    output logic                            LED0
`ifdef CAP_IRQ_EN
    ,
    output logic                            IRQ
`endif
);

    localparam int SPW = 32 / C_NUM_LANES;          // samples per word
    localparam int CW  = $clog2(SPW);
    localparam int PW  = $clog2(C_BUF_DEPTH);
    localparam int RAW = PW + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SPW - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(C_BUF_DEPTH - 1);
    localparam logic [11:0]   NWORDS   = 12'(2 * C_BUF_DEPTH);

    // Capture state
    logic [1:0]    state_q, state_d;
    logic          active_q, active_d;
    logic [1:0]    rdy_q, rdy_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;
    logic          enable_q, enable_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   word_q, word_d;
    // AXI state
    logic          awready_q, awready_d;
    logic          bvalid_q, bvalid_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    rstate_q, rstate_d;
    logic [12:0]   araddr_q, araddr_d;
    logic          hit_q, hit_d;
`ifdef CAP_IRQ_EN
    logic [1:0]    mask_q, mask_d;
    logic          irq_q, irq_d;
`endif

    logic           wr_fire, ctrl_wr, clr_ovf, ar_fire, commit, ram_we;
    logic [1:0]     rel, rdy_rel;
    logic [31:0]    packed_w, ram_rdata, reg_rdata;
    logic [11:0]    ar_idx;
    logic [RAW-1:0] ram_raddr;

    // Address high bits, strobes and upper data bits are never decoded
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WSTRB, S_AXI_WDATA};

    assign wr_fire  = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign ctrl_wr  = wr_fire && (S_AXI_AWADDR[12:0] == A_CTRL);
    assign rel      = ctrl_wr ? {S_AXI_WDATA[CTRL_REL1], S_AXI_WDATA[CTRL_REL0]} : 2'b00;
    assign clr_ovf  = ctrl_wr & S_AXI_WDATA[CTRL_CLR_OVF];
    assign rdy_rel  = rdy_q & ~rel;   // releases take effect before any fill completion
    assign packed_w = {LVDS_DATA, word_q[31:C_NUM_LANES]};
    assign commit   = LVDS_VALID && (cnt_q == LAST_CNT);
    assign ar_fire  = arready_q & S_AXI_ARVALID;
    assign ar_idx   = {2'b00, S_AXI_ARADDR[11:2]};
    assign ram_raddr = ar_idx[RAW-1:0];

    lvds_cap_ram #(.DEPTH(2 * C_BUF_DEPTH), .AW(RAW)) u_ram (
        .clk   (S_AXI_ACLK),
        .we    (ram_we),
        .waddr ({active_q, wptr_q}),
        .wdata (packed_w),
        .re    (ar_fire),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Capture FSM, packer, buffer flags and overflow accounting
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        rdy_d    = rdy_rel;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        enable_d = ctrl_wr ? S_AXI_WDATA[CTRL_ENABLE] : enable_q;
        wptr_d   = wptr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        ram_we   = 1'b0;
        if (!enable_q || state_q == S_IDLE) begin
            state_d = enable_q ? S_FILL : S_IDLE;
            wptr_d  = '0;
            cnt_d   = '0;
            word_d  = '0;
        end else begin
            if (LVDS_VALID) begin
                word_d = packed_w;
                cnt_d  = commit ? '0 : cnt_q + 1'b1;
            end
            if (state_q == S_FILL) begin
                if (commit) begin
                    ram_we = 1'b1;
                    if (wptr_q == LAST_PTR) begin
                        wptr_d          = '0;
                        rdy_d[active_q] = 1'b1;
                        if (!rdy_rel[~active_q]) active_d = ~active_q;
                        else                     state_d  = S_STALL;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end else if (!rdy_rel[~active_q]) begin
                active_d = ~active_q;
                cnt_d    = '0;
                word_d   = '0;
                state_d  = S_FILL;
            end else if (commit) begin
                ovf_d  = 1'b1;
                drop_d = sat_inc16(drop_q);
            end
        end
        if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    // Register readback mux, using the address latched at the AR handshake
    always_comb begin
        reg_rdata = '0;
        case (araddr_q)
            A_CTRL:   reg_rdata[CTRL_ENABLE] = enable_q;
            A_STATUS: begin
                reg_rdata[ST_RDY0]   = rdy_q[0];
                reg_rdata[ST_RDY1]   = rdy_q[1];
                reg_rdata[ST_ACTIVE] = active_q;
                reg_rdata[ST_OVF]    = ovf_q;
                reg_rdata[ST_STALL]  = (state_q == S_STALL);
                reg_rdata[31:16]     = drop_q;
            end
            A_WPTR:   reg_rdata = 32'(wptr_q);
`ifdef CAP_IRQ_EN
            A_IRQ_MASK: reg_rdata[1:0] = mask_q;
`endif
            default:  reg_rdata = '0;
        endcase
    end

    // AXI write/read handshakes and the read FSM
    always_comb begin
        awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
        bvalid_d  = bvalid_q & ~S_AXI_BREADY;
        if (wr_fire) bvalid_d = 1'b1;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rstate_d  = rstate_q;
        araddr_d  = araddr_q;
        hit_d     = hit_q;
        case (rstate_q)
            R_IDLE: begin
                arready_d = S_AXI_ARVALID & ~arready_q & ~rvalid_q;
                if (ar_fire) begin
                    arready_d = 1'b0;
                    araddr_d  = S_AXI_ARADDR[12:0];
                    hit_d     = S_AXI_ARADDR[12] && (ar_idx < NWORDS);
                    rstate_d  = R_RAM;
                end
            end
            R_RAM: begin
                rdata_d  = hit_q ? ram_rdata : reg_rdata;
                rvalid_d = 1'b1;
                rstate_d = R_DATA;
            end
            default: begin
                if (S_AXI_RREADY) begin
                    rvalid_d = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
        endcase
    end

`ifdef CAP_IRQ_EN
    // Interrupt mask register and registered interrupt level
    always_comb begin
        mask_d = mask_q;
        if (wr_fire && S_AXI_AWADDR[12:0] == A_IRQ_MASK) mask_d = S_AXI_WDATA[1:0];
        irq_d = ((rdy_q[0] | rdy_q[1]) & mask_q[0]) | (ovf_q & mask_q[1]);
    end

    // IRQ state flops
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign IRQ = irq_q;
`endif

    // State flops
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q   <= S_IDLE;
            active_q  <= 1'b0;
            rdy_q     <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
            enable_q  <= 1'b0;
            wptr_q    <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rstate_q  <= R_IDLE;
            araddr_q  <= '0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            rdy_q     <= rdy_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            enable_q  <= enable_d;
            wptr_q    <= wptr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rstate_q  <= rstate_d;
            araddr_q  <= araddr_d;
            hit_q     <= hit_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign LED0          = (state_q == S_FILL);

endmodule
